// File: rtl/up16_hazard_if.sv
// Signal bundle between the uP16 ID stage and the hazard/forwarding unit.
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface up16_hazard_if #(
    parameter int DSIZE = 16,
    parameter int RADDR = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [RADDR-1:0] id_rs1;
    logic [RADDR-1:0] id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [RADDR-1:0] id_rd;
    logic             id_wen;
    logic             id_load;
    logic             id_redirect;
    logic             mem_busy;
    logic [DSIZE-1:0] ex_res;
    logic [DSIZE-1:0] mem_res;
    logic [DSIZE-1:0] wb_res;
    logic [DSIZE-1:0] rf_rd1;
    logic [DSIZE-1:0] rf_rd2;
    logic [DSIZE-1:0] opnd1;
    logic [DSIZE-1:0] opnd2;
    logic             hold_pc;
    logic             bubble_ex;
    logic             flush_ifid;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_load,
               id_redirect, mem_busy, ex_res, mem_res, wb_res, rf_rd1, rf_rd2,
        input  opnd1, opnd2, hold_pc, bubble_ex, flush_ifid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_load,
               id_redirect, mem_busy, ex_res, mem_res, wb_res, rf_rd1, rf_rd2,
        output opnd1, opnd2, hold_pc, bubble_ex, flush_ifid, stall_cnt
    );
endinterface

// File: rtl/up16_hazard_unit.sv
// uP16 hazard/forwarding controller: 3-entry destination scoreboard (EX, MEM, WB).
// Define UP16_HAZARD_FWD_EN for the forwarding network; otherwise a pure RAW interlock.
module up16_hazard_unit #(
    parameter int DSIZE   = 16,
    parameter int RADDR   = 3,
    parameter int ZERO_R0 = 1,
    parameter int CNT_W   = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    up16_hazard_if.slave bus
);
    typedef struct packed {
        logic             v;
        logic [RADDR-1:0] rd;
        logic             wen;
    } sb_t;

    sb_t              r_ex, r_mem, r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    sb_t              w_id_entry;
    logic             w_m1_ex, w_m1_mem, w_m1_wb;
    logic             w_m2_ex, w_m2_mem, w_m2_wb;
    logic             w_haz;
    logic             w_hold, w_bubble, w_flush;

    function automatic logic f_match(input sb_t s, input logic [RADDR-1:0] r, input logic use_r);
        return s.v && s.wen && (s.rd == r) && use_r && !((ZERO_R0 != 0) && (r == '0));
    endfunction

    assign w_m1_ex  = f_match(r_ex,  bus.id_rs1, bus.id_use1);
    assign w_m1_mem = f_match(r_mem, bus.id_rs1, bus.id_use1);
    assign w_m1_wb  = f_match(r_wb,  bus.id_rs1, bus.id_use1);
    assign w_m2_ex  = f_match(r_ex,  bus.id_rs2, bus.id_use2);
    assign w_m2_mem = f_match(r_mem, bus.id_rs2, bus.id_use2);
    assign w_m2_wb  = f_match(r_wb,  bus.id_rs2, bus.id_use2);

`ifdef UP16_HAZARD_FWD_EN
    logic r_ex_load;

    function automatic logic [DSIZE-1:0] f_fwd(input logic m_ex, input logic m_mem,
                                               input logic m_wb, input logic [DSIZE-1:0] rf);
        if (m_ex)       return bus.ex_res;
        else if (m_mem) return bus.mem_res;
        else if (m_wb)  return bus.wb_res;
        else            return rf;
    endfunction

    // Only a load still in EX cannot be bypassed; everything else is forwarded.
    assign w_haz     = (w_m1_ex | w_m2_ex) & r_ex_load;
    assign bus.opnd1 = f_fwd(w_m1_ex & !r_ex_load, w_m1_mem, w_m1_wb, bus.rf_rd1);
    assign bus.opnd2 = f_fwd(w_m2_ex & !r_ex_load, w_m2_mem, w_m2_wb, bus.rf_rd2);
`else
    assign w_haz     = w_m1_ex | w_m1_mem | w_m1_wb | w_m2_ex | w_m2_mem | w_m2_wb;
    assign bus.opnd1 = bus.rf_rd1;
    assign bus.opnd2 = bus.rf_rd2;
`endif

    // Freeze beats stall, stall beats redirect (branch re-resolves once operands are ready).
    always_comb begin
        w_hold   = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        if (bus.mem_busy) begin
            w_hold = 1'b1;
        end else if (w_haz && bus.id_valid) begin
            w_hold   = 1'b1;
            w_bubble = 1'b1;
        end else if (bus.id_redirect && bus.id_valid) begin
            w_flush = 1'b1;
        end
    end

    assign w_id_entry.v   = bus.id_valid && !w_bubble;
    assign w_id_entry.rd  = bus.id_rd;
    assign w_id_entry.wen = bus.id_wen;

    assign bus.hold_pc    = w_hold;
    assign bus.bubble_ex  = w_bubble;
    assign bus.flush_ifid = w_flush;
    assign bus.stall_cnt  = r_stall_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ex.v      <= 1'b0;
            r_mem.v     <= 1'b0;
            r_wb.v      <= 1'b0;
            r_stall_cnt <= '0;
`ifdef UP16_HAZARD_FWD_EN
            r_ex_load   <= 1'b0;
`endif
        end else if (!bus.mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_id_entry;
`ifdef UP16_HAZARD_FWD_EN
            r_ex_load <= w_id_entry.v && bus.id_load;
`endif
            if (w_bubble && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_up16_hazard_unit.sv
// Directed vector bench for up16_hazard_unit; expectations follow UP16_HAZARD_FWD_EN.
// A second instance with a 2-bit stall counter shadows the first to exercise saturation.
module tb_up16_hazard_unit;
    localparam logic [15:0] R1 = 16'h1111;
    localparam logic [15:0] R2 = 16'h2222;
    localparam logic [15:0] EX = 16'h0005;
    localparam logic [15:0] MM = 16'h00A0;
    localparam logic [15:0] WB = 16'h00B0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    up16_hazard_if #(.DSIZE(16), .RADDR(3), .CNT_W(16)) u_if ();
    up16_hazard_if #(.DSIZE(16), .RADDR(3), .CNT_W(2))  u_if2 ();

    up16_hazard_unit #(.DSIZE(16), .RADDR(3), .ZERO_R0(1), .CNT_W(16)) u_dut (
        .Clk(clk), .Rst(rst), .bus(u_if.slave));
    up16_hazard_unit #(.DSIZE(16), .RADDR(3), .ZERO_R0(1), .CNT_W(2)) u_dut2 (
        .Clk(clk), .Rst(rst), .bus(u_if2.slave));

    assign u_if2.id_valid    = u_if.id_valid;
    assign u_if2.id_rs1      = u_if.id_rs1;
    assign u_if2.id_rs2      = u_if.id_rs2;
    assign u_if2.id_use1     = u_if.id_use1;
    assign u_if2.id_use2     = u_if.id_use2;
    assign u_if2.id_rd       = u_if.id_rd;
    assign u_if2.id_wen      = u_if.id_wen;
    assign u_if2.id_load     = u_if.id_load;
    assign u_if2.id_redirect = u_if.id_redirect;
    assign u_if2.mem_busy    = u_if.mem_busy;
    assign u_if2.ex_res      = u_if.ex_res;
    assign u_if2.mem_res     = u_if.mem_res;
    assign u_if2.wb_res      = u_if.wb_res;
    assign u_if2.rf_rd1      = u_if.rf_rd1;
    assign u_if2.rf_rd2      = u_if.rf_rd2;

    typedef struct {
        logic        rst, busy, valid;
        logic [2:0]  rs1, rs2;
        logic        u1, u2;
        logic [2:0]  rd;
        logic        wen, load, redir;
        logic        hold, bub, flush;
        logic [15:0] o1, o2;
        int          cnt;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t V(input logic rst_i, busy, valid, input logic [2:0] rs1, rs2,
                               input logic u1, u2, input logic [2:0] rd,
                               input logic wen, load, redir, hold, bub, flush,
                               input logic [15:0] o1, o2, input int cnt);
        vec_t v;
        v.rst = rst_i; v.busy = busy; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.rd = rd; v.wen = wen; v.load = load; v.redir = redir;
        v.hold = hold; v.bub = bub; v.flush = flush; v.o1 = o1; v.o2 = o2; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
`ifdef UP16_HAZARD_FWD_EN
        //          rst bsy vld rs1 rs2 u1 u2 rd wen ld rdr | hold bub fl  o1  o2  cnt
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0)); // reset state
        vq.push_back(V(0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 0,  0, 0, 0, R1, R2, 0)); // ADD r1
        vq.push_back(V(0, 0, 1, 1, 1, 1, 1, 2, 1, 0, 0,  0, 0, 0, EX, EX, 0)); // r1 from EX
        vq.push_back(V(0, 0, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, MM, EX, 0));
        vq.push_back(V(0, 0, 1, 1, 3, 1, 0, 4, 0, 0, 0,  0, 0, 0, WB, R2, 0));
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, R1, R2, 0)); // LD r3
        vq.push_back(V(0, 0, 1, 3, 4, 1, 1, 4, 1, 0, 0,  1, 1, 0, R1, R2, 0)); // load-use
        vq.push_back(V(0, 0, 1, 3, 4, 1, 1, 4, 1, 0, 0,  0, 0, 0, MM, R2, 1));
        vq.push_back(V(0, 0, 1, 5, 6, 1, 1, 0, 1, 0, 0,  0, 0, 0, R1, R2, 1)); // write r0
        vq.push_back(V(0, 0, 1, 0, 0, 1, 1, 5, 1, 0, 0,  0, 0, 0, R1, R2, 1)); // read r0
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, R1, R2, 1)); // redirect
        vq.push_back(V(0, 0, 1, 7, 0, 1, 0, 6, 1, 1, 0,  0, 0, 0, R1, R2, 1)); // LD r6
        vq.push_back(V(0, 1, 1, 6, 5, 1, 1, 0, 0, 0, 1,  1, 0, 0, R1, WB, 1)); // busy+haz+redir
        vq.push_back(V(0, 1, 1, 6, 5, 1, 1, 0, 0, 0, 1,  1, 0, 0, R1, WB, 1));
        vq.push_back(V(0, 0, 1, 6, 5, 1, 1, 0, 0, 0, 1,  1, 1, 0, R1, WB, 1));
        vq.push_back(V(0, 0, 1, 6, 5, 1, 1, 0, 0, 0, 1,  0, 0, 1, MM, R2, 2));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0, R1, R2, 2)); // LD r1
        vq.push_back(V(0, 0, 1, 1, 0, 1, 0, 2, 1, 0, 0,  1, 1, 0, R1, R2, 2));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 0, 2, 1, 0, 0,  0, 0, 0, MM, R2, 3));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, R1, R2, 3)); // LD r2
        vq.push_back(V(0, 0, 1, 0, 2, 0, 1, 3, 1, 0, 0,  1, 1, 0, R1, MM, 3));
        vq.push_back(V(0, 0, 1, 0, 2, 0, 1, 3, 1, 0, 0,  0, 0, 0, R1, MM, 4)); // 2-bit saturated
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, R1, R2, 4)); // LD r4
        vq.push_back(V(1, 0, 1, 4, 0, 1, 0, 5, 1, 0, 0,  1, 1, 0, R1, R2, 4)); // reset mid-stall
        vq.push_back(V(0, 0, 1, 4, 0, 1, 0, 5, 1, 0, 0,  0, 0, 0, R1, R2, 0));
        vq.push_back(V(0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, EX, R2, 0)); // invalid ID
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0));
`else
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0)); // reset state
        vq.push_back(V(0, 0, 1, 2, 3, 1, 1, 1, 1, 0, 0,  0, 0, 0, R1, R2, 0)); // ADD r1
        vq.push_back(V(0, 0, 1, 1, 5, 1, 1, 2, 1, 0, 0,  1, 1, 0, R1, R2, 0)); // r1 in EX
        vq.push_back(V(0, 0, 1, 1, 5, 1, 1, 2, 1, 0, 0,  1, 1, 0, R1, R2, 1)); // r1 in MEM
        vq.push_back(V(0, 0, 1, 1, 5, 1, 1, 2, 1, 0, 0,  1, 1, 0, R1, R2, 2)); // r1 in WB
        vq.push_back(V(0, 0, 1, 1, 5, 1, 1, 2, 1, 0, 0,  0, 0, 0, R1, R2, 3)); // released
        vq.push_back(V(0, 0, 1, 5, 6, 1, 1, 0, 1, 0, 0,  0, 0, 0, R1, R2, 3)); // write r0
        vq.push_back(V(0, 0, 1, 0, 0, 1, 1, 5, 1, 0, 0,  0, 0, 0, R1, R2, 3)); // read r0
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, R1, R2, 3)); // redirect
        vq.push_back(V(0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 1,  1, 0, 0, R1, R2, 3)); // busy+haz+redir
        vq.push_back(V(0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 1,  1, 0, 0, R1, R2, 3));
        vq.push_back(V(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 1,  1, 1, 0, R1, R2, 3));
        vq.push_back(V(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 1,  1, 1, 0, R1, R2, 4)); // 2-bit saturated
        vq.push_back(V(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 1,  0, 0, 1, R1, R2, 5));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 0, 0, R1, R2, 5)); // LD r3
        vq.push_back(V(0, 0, 1, 3, 0, 1, 0, 4, 1, 0, 0,  1, 1, 0, R1, R2, 5));
        vq.push_back(V(1, 0, 1, 3, 0, 1, 0, 4, 1, 0, 0,  1, 1, 0, R1, R2, 6)); // reset mid-stall
        vq.push_back(V(0, 0, 1, 3, 0, 1, 0, 4, 1, 0, 0,  0, 0, 0, R1, R2, 0));
        vq.push_back(V(0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0)); // invalid ID
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, R1, R2, 0));
`endif

        rst = 1'b1;
        u_if.id_valid = 0; u_if.id_rs1 = 0; u_if.id_rs2 = 0; u_if.id_use1 = 0;
        u_if.id_use2 = 0; u_if.id_rd = 0; u_if.id_wen = 0; u_if.id_load = 0;
        u_if.id_redirect = 0; u_if.mem_busy = 0;
        u_if.ex_res = EX; u_if.mem_res = MM; u_if.wb_res = WB;
        u_if.rf_rd1 = R1; u_if.rf_rd2 = R2;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst              = vq[i].rst;
            u_if.mem_busy    = vq[i].busy;
            u_if.id_valid    = vq[i].valid;
            u_if.id_rs1      = vq[i].rs1;
            u_if.id_rs2      = vq[i].rs2;
            u_if.id_use1     = vq[i].u1;
            u_if.id_use2     = vq[i].u2;
            u_if.id_rd       = vq[i].rd;
            u_if.id_wen      = vq[i].wen;
            u_if.id_load     = vq[i].load;
            u_if.id_redirect = vq[i].redir;
            #2;
            n_vec++;
            chk("hold_pc",    i, 32'(u_if.hold_pc),    32'(vq[i].hold));
            chk("bubble_ex",  i, 32'(u_if.bubble_ex),  32'(vq[i].bub));
            chk("flush_ifid", i, 32'(u_if.flush_ifid), 32'(vq[i].flush));
            chk("opnd1",      i, 32'(u_if.opnd1),      32'(vq[i].o1));
            chk("opnd2",      i, 32'(u_if.opnd2),      32'(vq[i].o2));
            chk("stall_cnt",  i, 32'(u_if.stall_cnt),  32'(vq[i].cnt));
            chk("stall_cnt2", i, 32'(u_if2.stall_cnt), (vq[i].cnt > 3) ? 32'd3 : 32'(vq[i].cnt));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
